// File: rtl/recip_arbiter_pkg.sv
// Shared types and constants for the reciprocal-unit arbiter and its
// reciprocal datapath.
package recip_arbiter_pkg;

  localparam int TAG_MAX_W = 8;

  // Result returned for a zero operand; sliced to the result width by users.
  localparam logic [63:0] DIV0_RESULT = '1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic                 zero;
  } tag_entry_t;

  function automatic int recip_latency(input int iterations);
    return 7 + 3 * iterations;
  endfunction

endpackage

// File: rtl/recip_arbiter_if.sv
// Request/response bundle between the clients and the reciprocal arbiter.
interface recip_arbiter_if #(
  parameter int NUMBER_WIDTH = 24,
  parameter int ITERATIONS   = 2,
  parameter int REQUESTERS   = 4
);
  import recip_arbiter_pkg::*;

  localparam int LATENCY  = recip_latency(ITERATIONS);
  localparam int FLIGHT_W = $clog2(LATENCY + 2);

  logic [REQUESTERS-1:0]              req_valid;
  logic [REQUESTERS-1:0]              req_ready;
  logic [REQUESTERS*NUMBER_WIDTH-1:0] req_data;
  logic [REQUESTERS-1:0]              rsp_valid;
  logic [REQUESTERS-1:0]              rsp_ready;
  logic [2*NUMBER_WIDTH-1:0]          rsp_data;
  logic                               rsp_div0;
  logic [FLIGHT_W-1:0]                in_flight;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_div0, in_flight
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_div0, in_flight
  );
endinterface

// File: rtl/XRecip.sv
// Pipelined reciprocal: out = 2^NUMBER_WIDTH / in, advancing only when ce is high.
module XRecip
  import recip_arbiter_pkg::*;
#(
  parameter int NUMBER_WIDTH = 24,
  parameter int ITERATIONS   = 2
) (
  input  logic                      clk,
  input  logic                      ce,
  input  logic [NUMBER_WIDTH-1:0]   in_i,
  output logic [2*NUMBER_WIDTH-1:0] out_o
);

  localparam int LATENCY = recip_latency(ITERATIONS);
  localparam int OW      = 2 * NUMBER_WIDTH;

  logic [OW-1:0] quot;
  logic [OW-1:0] stage_q [LATENCY];

  // A zero operand yields 0 here; the arbiter substitutes its own marker.
  always_comb begin
    quot = '0;
    if (in_i != '0) quot = (OW'(1) << NUMBER_WIDTH) / {{NUMBER_WIDTH{1'b0}}, in_i};
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      stage_q[0] <= quot;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin single grant per enabled clock; pointer moves past the winner.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic [W-1:0] rr_o
);

  logic [W-1:0] rr_q, rr_d;
  logic [W-1:0] cand;
  logic         hit;
  int           idx;

  // Walk from the far end so the candidate closest to the pointer wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    hit       = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      cand = W'(idx);
      if (en_i && req_i[cand]) begin
        hit       = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (hit) gnt_o[gnt_idx_o] = 1'b1;
    rr_d = rr_q;
    if (hit) rr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  assign rr_o = rr_q;

endmodule

// File: rtl/recip_arbiter.sv
// Shares one reciprocal pipeline among several clients; a tag pipe routes
// each result home and the whole pipe stalls while its owner is not ready.
module recip_arbiter
  import recip_arbiter_pkg::*;
#(
  parameter int NUMBER_WIDTH = 24,
  parameter int ITERATIONS   = 2,
  parameter int REQUESTERS   = 4
) (
  input logic            clk,
  input logic            resetn,
  recip_arbiter_if.slave bus
);

  localparam int LATENCY  = recip_latency(ITERATIONS);
  localparam int TAG_W    = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int FLIGHT_W = $clog2(LATENCY + 2);

  logic                      ce, run, stall_owner, consumed, gnt_any;
  logic [REQUESTERS-1:0]     gnt;
  logic [TAG_W-1:0]          gnt_idx, rr;
  logic [NUMBER_WIDTH-1:0]   operand;
  logic [2*NUMBER_WIDTH-1:0] unit_out;
  tag_entry_t                pipe_q [LATENCY];
  tag_entry_t                issue_d, out_e;
  logic [FLIGHT_W-1:0]       in_flight_q, in_flight_d;

  // No grants while reset is held, even if the stale pipe says ce is high.
  assign run = ce && resetn;

  rr_arbiter #(.N(REQUESTERS)) u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .en_i      (run),
    .req_i     (bus.req_valid),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .rr_o      (rr)
  );

  assign gnt_any = |gnt;

  always_comb begin
    operand = '0;
    if (gnt_any) operand = bus.req_data[int'(gnt_idx)*NUMBER_WIDTH +: NUMBER_WIDTH];
  end

  XRecip #(.NUMBER_WIDTH(NUMBER_WIDTH), .ITERATIONS(ITERATIONS)) u_recip (
    .clk   (clk),
    .ce    (ce),
    .in_i  (operand),
    .out_o (unit_out)
  );

  assign out_e = pipe_q[LATENCY-1];

  always_comb begin
    stall_owner = 1'b0;
    for (int i = 0; i < REQUESTERS; i++)
      if (out_e.tag == TAG_MAX_W'(i) && !bus.rsp_ready[i]) stall_owner = 1'b1;
  end

  assign ce       = !(out_e.valid && stall_owner);
  assign consumed = out_e.valid && !stall_owner;

  always_comb begin
    issue_d.valid = gnt_any;
    issue_d.tag   = TAG_MAX_W'(gnt_idx);
    issue_d.zero  = (operand == '0);
  end

  // Only valid bits are reset; tag/zero of an invalid entry are never looked at.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i].valid <= 1'b0;
    end else if (ce) begin
      pipe_q[0] <= issue_d;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    if (gnt_any && !consumed)      in_flight_d = in_flight_q + FLIGHT_W'(1);
    else if (!gnt_any && consumed) in_flight_d = in_flight_q - FLIGHT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) in_flight_q <= '0;
    else         in_flight_q <= in_flight_d;
  end

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < REQUESTERS; i++)
      bus.rsp_valid[i] = resetn && out_e.valid && (out_e.tag == TAG_MAX_W'(i));
  end

  assign bus.rsp_data  = out_e.zero ? DIV0_RESULT[2*NUMBER_WIDTH-1:0] : unit_out;
  assign bus.rsp_div0  = resetn && out_e.valid && out_e.zero;
  assign bus.req_ready = gnt;
  assign bus.in_flight = in_flight_q;

  always_ff @(posedge clk) begin
    if (run && bus.req_valid[rr]) assert (gnt_idx == rr);
  end

endmodule

// File: tb/tb_recip_arbiter.sv
// Bench for recip_arbiter: directed tables and sequences plus a random soak
// checked every cycle against a queue-based model of the shared unit.
module tb_recip_arbiter;

  localparam int NW  = 24;
  localparam int IT  = 2;
  localparam int RQ  = 4;
  localparam int LAT = 7 + 3 * IT;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  recip_arbiter_if #(.NUMBER_WIDTH(NW), .ITERATIONS(IT), .REQUESTERS(RQ)) bus ();

  recip_arbiter #(.NUMBER_WIDTH(NW), .ITERATIONS(IT), .REQUESTERS(RQ)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          owner;
    logic [23:0] x;
    int          age;
  } job_t;
  job_t q[$];
  int   rr_m = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] ref_recip(input logic [23:0] x);
    logic [63:0] num;
    if (x == 24'd0) return 48'hFFFF_FFFF_FFFF;
    num = 64'd1 << 24;
    return 48'(num / {40'd0, x});
  endfunction

  task automatic chk_data(input string nm, input logic [47:0] act, input logic [23:0] x);
    logic [47:0] r;
    bit          exact, ok;
    r     = ref_recip(x);
    exact = (x == 24'd0) || ((x & (x - 24'd1)) == 24'd0);
    if (exact) ok = (act == r);
    else       ok = (act == r) || (act == r + 48'd1) || (act + 48'd1 == r);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (operand %0h) at %0t", nm, act, r, x, $time);
    end
  endtask

  // Reference model: jobs age by one per enabled clock; the oldest one is at
  // the output once it has seen LAT enabled clocks.
  always @(negedge clk) begin
    logic [3:0] exp_ready, exp_valid;
    bit         head_out, ce_m;
    int         g, c;
    head_out  = (q.size() > 0) && (q[0].age == LAT);
    ce_m      = !(head_out && !bus.rsp_ready[q[0].owner]);
    exp_valid = '0;
    exp_ready = '0;
    g         = -1;
    if (resetn) begin
      if (head_out) exp_valid[q[0].owner] = 1'b1;
      if (ce_m)
        for (int k = 0; k < RQ; k++) begin
          c = (rr_m + k) % RQ;
          if (g < 0 && bus.req_valid[c]) g = c;
        end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("m_req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid));
    chk("m_rsp_div0", 64'(bus.rsp_div0), 64'(resetn && head_out && q[0].x == 24'd0));
    chk("m_in_flight", 64'(bus.in_flight), 64'(q.size()));
    if (resetn && head_out) chk_data("m_rsp_data", bus.rsp_data, q[0].x);

    if (!resetn) begin
      q.delete();
      rr_m = 0;
    end else if (ce_m) begin
      if (head_out) void'(q.pop_front());
      foreach (q[i]) q[i].age = q[i].age + 1;
      if (g >= 0) begin
        q.push_back('{g, bus.req_data[g*NW +: NW], 1});
        rr_m = (g + 1) % RQ;
      end
    end
  end

  task automatic set_req(input int cl, input logic [23:0] x);
    bus.req_data[cl*NW +: NW] = x;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      bus.req_valid = '0;
    end
  endtask

  vec_t tbl[10];

  initial begin
    logic [3:0] rv;
    int         r;
    logic [23:0] x;

    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b0001, 4'b0001};
    tbl[3] = '{4'b1001, 4'b1000};
    tbl[4] = '{4'b0000, 4'b0000};
    tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b0100, 4'b0100};
    tbl[7] = '{4'b0011, 4'b0001};
    tbl[8] = '{4'b1100, 4'b0100};
    tbl[9] = '{4'b1111, 4'b1000};

    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.rsp_ready = 4'b1111;
    resetn        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_in_flight", 64'(bus.in_flight), 64'd0);

    // Arbitration table; first entry lands in the first cycle out of reset.
    for (int i = 0; i < 10; i++) begin
      step();
      resetn = 1'b1;
      bus.req_valid = tbl[i].valid;
      for (int cl = 0; cl < RQ; cl++) set_req(cl, 24'(i * 4 + cl + 1));
      @(negedge clk);
      chk("tbl_req_ready", 64'(bus.req_ready), 64'(tbl[i].exp_ready));
    end
    idle(LAT + 3);

    // Single client: 4 then 1.
    for (int cyc = 0; cyc <= 15; cyc++) begin
      step();
      bus.req_valid = (cyc < 2) ? 4'b0100 : 4'b0000;
      set_req(2, (cyc == 0) ? 24'd4 : 24'd1);
      @(negedge clk);
      if (cyc == 0) chk("single_grant", 64'(bus.req_ready), 64'b0100);
      if (cyc == 12) chk("single_early", 64'(bus.rsp_valid), 64'd0);
      if (cyc == 13) begin
        chk("single_v0", 64'(bus.rsp_valid), 64'b0100);
        chk("single_d0", 64'(bus.rsp_data), 64'h400000);
      end
      if (cyc == 14) begin
        chk("single_v1", 64'(bus.rsp_valid), 64'b0100);
        chk("single_d1", 64'(bus.rsp_data), 64'h1000000);
      end
      if (cyc == 15) chk("single_end", 64'(bus.rsp_valid), 64'd0);
    end
    idle(LAT + 3);

    // Divide by zero between two ordinary operands.
    for (int cyc = 0; cyc <= 16; cyc++) begin
      step();
      case (cyc)
        0: begin bus.req_valid = 4'b0100; set_req(2, 24'd5); end
        1: begin bus.req_valid = 4'b1000; set_req(3, 24'd0); end
        2: begin bus.req_valid = 4'b0001; set_req(0, 24'd8); end
        default: bus.req_valid = 4'b0000;
      endcase
      @(negedge clk);
      if (cyc == 13) begin
        chk("dz_prev_v", 64'(bus.rsp_valid), 64'b0100);
        chk("dz_prev_z", 64'(bus.rsp_div0), 64'd0);
        chk_data("dz_prev_d", bus.rsp_data, 24'd5);
      end
      if (cyc == 14) begin
        chk("dz_v", 64'(bus.rsp_valid), 64'b1000);
        chk("dz_z", 64'(bus.rsp_div0), 64'd1);
        chk("dz_d", 64'(bus.rsp_data), 64'hFFFF_FFFF_FFFF);
      end
      if (cyc == 15) begin
        chk("dz_next_v", 64'(bus.rsp_valid), 64'b0001);
        chk("dz_next_z", 64'(bus.rsp_div0), 64'd0);
        chk("dz_next_d", 64'(bus.rsp_data), 64'h200000);
      end
    end
    idle(LAT + 3);

    // Back-pressure: client 1 holds its result for 5 cycles.
    for (int cyc = 0; cyc <= 20; cyc++) begin
      step();
      bus.rsp_ready = (cyc >= 18) ? 4'b1111 : 4'b1101;
      if (cyc == 0) begin
        bus.req_valid = 4'b0010;
        set_req(1, 24'd3);
      end else begin
        bus.req_valid = (cyc < 19) ? 4'b0101 : 4'b0000;
        set_req(0, 24'd5);
        set_req(2, 24'd7);
      end
      @(negedge clk);
      if (cyc >= 13 && cyc <= 17) begin
        chk("bp_valid", 64'(bus.rsp_valid), 64'b0010);
        chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
        chk("bp_in_flight", 64'(bus.in_flight), 64'd13);
        chk_data("bp_data", bus.rsp_data, 24'd3);
      end
      if (cyc == 18) begin
        chk("bp_release_v", 64'(bus.rsp_valid), 64'b0010);
        chk("bp_release_g", 64'(bus.req_ready), 64'b0100);
      end
      if (cyc == 19) chk("bp_next_v", 64'(bus.rsp_valid), 64'b0100);
    end
    idle(LAT + 16);

    // Six requests in flight, then a one-cycle reset, then all clients valid.
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      bus.req_valid = 4'b0010;
      set_req(1, 24'd9);
    end
    step();
    bus.req_valid = '0;
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    for (int k = 0; k <= 21; k++) begin
      step();
      resetn = 1'b1;
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      for (int cl = 0; cl < RQ; cl++) set_req(cl, 24'(16 + k * 4 + cl));
      @(negedge clk);
      if (k == 0) chk("mid_in_flight", 64'(bus.in_flight), 64'd0);
      if (k < 8) chk("fair_grant", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
      if (k < 13) chk("mid_no_stale", 64'(bus.rsp_valid), 64'd0);
      else if (k <= 20) chk("fair_order", 64'(bus.rsp_valid), 64'(4'b0001 << ((k - 13) % 4)));
      else chk("fair_end", 64'(bus.rsp_valid), 64'd0);
    end

    // Random soak.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step();
      rv = 4'($urandom);
      bus.req_valid = rv;
      for (int cl = 0; cl < RQ; cl++) begin
        r = int'($urandom_range(0, 7));
        if (r == 0)      x = 24'd0;
        else if (r == 1) x = 24'd1 << $urandom_range(0, 23);
        else             x = 24'($urandom);
        set_req(cl, x);
        bus.rsp_ready[cl] = ($urandom_range(0, 3) != 0);
      end
    end

    step();
    bus.req_valid = '0;
    bus.rsp_ready = 4'b1111;
    for (int cyc = 0; cyc < 4 * LAT; cyc++) begin
      if (q.size() == 0 && bus.in_flight == '0) break;
      step();
    end
    @(negedge clk);
    chk("drain_model", 64'(q.size()), 64'd0);
    chk("drain_in_flight", 64'(bus.in_flight), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/recip_arbiter.md
# recip_arbiter

Shares one pipelined `XRecip` reciprocal unit among `REQUESTERS` clients. Each client has a valid/ready request channel and a valid/ready response channel. The block grants at most one request per clock using round-robin order and tags each issued operand. It tracks the tag through a shift register matched to the unit latency and steers each result back to its owner. When the owner of the emerging result is not ready, it stalls the whole unit through `ce`.

## Interface
- `NUMBER_WIDTH`, 24, operand width; passed to `XRecip`.
- `ITERATIONS`, 2, Newton iterations; passed to `XRecip`.
- `REQUESTERS`, 4, number of clients (≥2).
- `LATENCY` (localparam), `7 + 3*ITERATIONS`, unit latency in `ce`-enabled clocks (13 at defaults).
- `TAG_W` (localparam), `$clog2(REQUESTERS)`.
- `clk` in 1: the single clock.
- `resetn` in 1: synchronous, active-low reset.
- `req_valid` in REQUESTERS: per-client request valid.
- `req_ready` out REQUESTERS: per-client grant; a transfer happens when valid && ready.
- `req_data` in REQUESTERS*NUMBER_WIDTH: operands; client i occupies bits [i*NUMBER_WIDTH +: NUMBER_WIDTH].
- `rsp_valid` out REQUESTERS: result valid, at most one bit high.
- `rsp_ready` in REQUESTERS: per-client result accept.
- `rsp_data` out 2*NUMBER_WIDTH: shared result bus, fixed-point as produced by `XRecip`.
- `rsp_div0` out 1: the current result came from a zero operand.
- `in_flight` out $clog2(LATENCY+2): number of valid entries in the pipeline.

## Operation
- **Stall:**
  - `ce = !(out_valid && !rsp_ready[out_tag])`.
  - `ce` drives `XRecip.ce` and the tag pipe.
  - With `ce` low, nothing advances and nothing is granted.
- **Arbitration:** only when `ce`=1.
  - Starting from pointer `rr`, the first client with `req_valid` set is granted.
  - `req_ready[g]`=1 only for that client; all other bits are 0.
  - On a grant, `rr` becomes `(g+1) mod REQUESTERS`; with no grant, `rr` is held.
  - `req_ready` depends combinationally on `req_valid`, `rr` and `ce`.
- **Issue:**
  - `XRecip.in` = `req_data` of the granted client, or 0 when there is no grant.
- **Tag pipe:**
  - LATENCY stages of {valid, tag, zero}, shifted on `ce`.
  - Stage 0 receives {grant, g, operand==0}.
  - The last stage is {out_valid, out_tag, out_zero} and is aligned with `XRecip.out`.
- **Response:**
  - `rsp_valid[i] = out_valid && out_tag==i`.
  - `rsp_data` = all-ones when `out_zero` is set, otherwise `XRecip.out`.
  - `rsp_div0 = out_valid && out_zero`.
  - A result is consumed on the cycle it is valid with ready high; the pipe then advances.
- **`in_flight`:**
  - +1 on a grant, −1 on a consumed result, unchanged when both or neither occur.
  - Never exceeds LATENCY.
- **Reset** (while `resetn`=0 at a `clk` edge):
  - Clears all tag-pipe valid bits and sets `rr`=0 and `in_flight`=0.
  - `rsp_valid`=0, `rsp_div0`=0 and `req_ready`=0 while reset is asserted.
  - Reset mid-operation discards in-flight results; the unit's datapath registers are not reset, and their contents are ignored because the valid bits are cleared.

## Timing
- Request accepted at edge T produces `rsp_valid` in the cycle after edge T+LATENCY−1. With no stall, that is LATENCY cycles after the acceptance cycle.
- Each `ce`-low cycle adds exactly one cycle.
- Throughput: one issue and one result per clock when all `rsp_ready` are high.
- `rsp_data`, `rsp_valid` and `rsp_div0` stay stable while stalled.
- Results return in issue order; clients see their own results in request order.
- With a single active client, that client is granted every cycle.
- With all clients valid, grants go strictly 0,1,2,3,0,…
- A client whose result is stalling the pipe may also be a requester; it is not granted until the stall clears.
- The first grant may occur in the first cycle after `resetn` goes high.

## Structure
- Shared package holds:
  - the `LATENCY` formula function `recip_latency(ITERATIONS)`;
  - the tag-pipe entry struct {valid, tag, zero};
  - the div-by-zero result constant (all-ones).
- Sub-module `rr_arbiter`, instantiated once:
  - inputs: request vector, enable (`ce`), `clk`, `resetn`;
  - outputs: one-hot grant and grant index, plus the `rr` pointer.
- `XRecip` is instantiated once inside `recip_arbiter`.
- The tag pipe is an inline shift register, not a separate module.

## Test plan
- **Single request:**
  - Stimulus: client 2 sends 4 and then 1.
  - Response: `rsp_valid[2]` at +13 cycles with `rsp_data`=0x400000, then 0x1000000 the next cycle.
- **Fairness:**
  - Stimulus: all 4 clients hold `req_valid` for 8 cycles.
  - Response: grants 0,1,2,3,0,1,2,3; results return in that order, one per cycle.
- **Back-pressure:**
  - Stimulus: `rsp_ready[1]`=0 for 5 cycles while client 1's result is at the output.
  - Response: `ce`=0, `req_ready`=0, `rsp_data` stable, `in_flight` constant; the result and pipeline resume the cycle after ready returns.
- **Divide by zero:**
  - Stimulus: client 3 sends 0.
  - Response: `rsp_valid[3]` with `rsp_div0`=1 and `rsp_data`=0xFFFFFFFFFFFF; neighbouring results are unaffected.
- **Reset mid-flight:**
  - Stimulus: issue 6 requests, then assert `resetn`=0 for 1 cycle.
  - Response: no `rsp_valid` for the discarded results, `in_flight`=0, and the first grant after reset goes to client 0.
- **Random soak:**
  - Stimulus: random valid and ready patterns over 10k cycles.
  - Response: every request answered exactly once, in order, and matching a reference model (within 1 LSB; exact for powers of two).
